// File: rtl/div_sign_ctrl.sv
// ---------------------------------------------------------------------------
// div_sign_ctrl
//
// Sequencer around the 32-cycle unsigned restoring divider core. It accepts
// DIV/DIVU requests, rejects a zero divisor and turns signed operands into
// magnitudes for the core. It waits for the core to finish and restores the
// MIPS signs on the quotient (LO) and remainder (HI). BUSY stalls the control
// unit while an operation is in flight.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high reset
//   DIV_REQ        request pulse, sampled only in IDLE
//   DIV_SIGNED     1 = DIV (signed), 0 = DIVU; sampled with DIV_REQ
//   RS, RT         dividend / divisor; sampled with DIV_REQ
//   DIV_END_IN     core done flag (level, held until the next start)
//   CORE_HI        core remainder
//   CORE_LO        core quotient
//   CORE_DIV_START core start, high for exactly one cycle
//   CORE_A/CORE_B  registered magnitude dividend / divisor to the core
//   HI_OUT/LO_OUT  registered final remainder / quotient
//   HILO_WRITE     one-cycle strobe: HI_OUT/LO_OUT valid, write HI/LO
//   BUSY           high from accepted request until HILO_WRITE or error
//   DIV_ZERO_EXC   one-cycle pulse: divisor was zero
//   TIMEOUT_ERR    one-cycle pulse: core never finished
//   dbg_state      current FSM state (IDLE=0, LAUNCH=1, WAIT=2, FIX=3)
//
// Handshake: a request is taken on any rising edge where DIV_REQ=1 and the
// FSM is IDLE (BUSY=0); there is no ready signal and requests arriving while
// busy are dropped, not queued. Exactly one of HILO_WRITE, DIV_ZERO_EXC or
// TIMEOUT_ERR pulses for one cycle per accepted request, unless reset
// abandons the operation first. HI_OUT/LO_OUT are valid while HILO_WRITE=1
// and hold until the next successful operation.
// ---------------------------------------------------------------------------
module div_sign_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             DIV_REQ,
    input  logic             DIV_SIGNED,
    input  logic [WIDTH-1:0] RS,
    input  logic [WIDTH-1:0] RT,
    input  logic             DIV_END_IN,
    input  logic [WIDTH-1:0] CORE_HI,
    input  logic [WIDTH-1:0] CORE_LO,
    output logic             CORE_DIV_START,
    output logic [WIDTH-1:0] CORE_A,
    output logic [WIDTH-1:0] CORE_B,
    output logic [WIDTH-1:0] HI_OUT,
    output logic [WIDTH-1:0] LO_OUT,
    output logic             HILO_WRITE,
    output logic             BUSY,
    output logic             DIV_ZERO_EXC,
    output logic             TIMEOUT_ERR,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FIX    = 2'd3
    } state_t;

    // Counter only has to reach TIMEOUT-1: WAIT gives up on the edge that
    // would complete the TIMEOUT-th WAIT cycle.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t           state, state_next;
    logic [CW-1:0]    wait_cnt, wait_cnt_next;
    logic             neg_q, neg_q_next;
    logic             neg_r, neg_r_next;
    logic [WIDTH-1:0] core_a_next, core_b_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             hilo_write_next;
    logic             busy_next;
    logic             zero_next;
    logic             timeout_next;

    // Sign of each operand only matters for DIV; DIVU treats bit 31 as data.
    logic rs_neg, rt_neg;
    assign rs_neg = DIV_SIGNED & RS[WIDTH-1];
    assign rt_neg = DIV_SIGNED & RT[WIDTH-1];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            CORE_A       <= '0;
            CORE_B       <= '0;
            HI_OUT       <= '0;
            LO_OUT       <= '0;
            HILO_WRITE   <= 1'b0;
            BUSY         <= 1'b0;
            DIV_ZERO_EXC <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            state        <= state_next;
            wait_cnt     <= wait_cnt_next;
            neg_q        <= neg_q_next;
            neg_r        <= neg_r_next;
            CORE_A       <= core_a_next;
            CORE_B       <= core_b_next;
            HI_OUT       <= hi_next;
            LO_OUT       <= lo_next;
            HILO_WRITE   <= hilo_write_next;
            BUSY         <= busy_next;
            DIV_ZERO_EXC <= zero_next;
            TIMEOUT_ERR  <= timeout_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        wait_cnt_next   = wait_cnt;
        neg_q_next      = neg_q;
        neg_r_next      = neg_r;
        core_a_next     = CORE_A;
        core_b_next     = CORE_B;
        hi_next         = HI_OUT;
        lo_next         = LO_OUT;
        hilo_write_next = 1'b0;
        busy_next       = BUSY;
        zero_next       = 1'b0;
        timeout_next    = 1'b0;

        case (state)
            S_IDLE: begin
                if (DIV_REQ) begin
                    if (RT == '0) begin
                        // Zero divisor never reaches the core.
                        zero_next = 1'b1;
                    end else begin
                        // Quotient is negative when operand signs differ;
                        // remainder takes the sign of the dividend.
                        neg_q_next  = rs_neg ^ rt_neg;
                        neg_r_next  = rs_neg;
                        // 0x80000000 negates to itself, which is already the
                        // correct unsigned magnitude.
                        core_a_next = rs_neg ? -RS : RS;
                        core_b_next = rt_neg ? -RT : RT;
                        busy_next   = 1'b1;
                        state_next  = S_LAUNCH;
                    end
                end
            end

            S_LAUNCH: begin
                wait_cnt_next = '0;
                state_next    = S_WAIT;
            end

            S_WAIT: begin
                if (DIV_END_IN) begin
                    state_next = S_FIX;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_next = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end

            S_FIX: begin
                lo_next         = neg_q ? -CORE_LO : CORE_LO;
                hi_next         = neg_r ? -CORE_HI : CORE_HI;
                hilo_write_next = 1'b1;
                busy_next       = 1'b0;
                state_next      = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Start is a decode of the state register, so it is high for exactly the
    // single LAUNCH cycle and glitch-free.
    assign CORE_DIV_START = (state == S_LAUNCH);
    assign dbg_state      = state;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_sign_ctrl
//
// Bench for div_sign_ctrl with a behavioural 32-cycle divider core model.
// Table of DIV/DIVU vectors plus hand-written sequences for zero divisor,
// ignored request, mid-operation reset, timeout and back-to-back requests.
// ---------------------------------------------------------------------------
module tb_div_sign_ctrl;

    localparam int TIMEOUT = 40;
    localparam int LAT     = 35;   // edges from request edge to HILO_WRITE

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT ----------------
    logic        DIV_REQ = 1'b0;
    logic        DIV_SIGNED = 1'b0;
    logic [31:0] RS = '0;
    logic [31:0] RT = '0;
    logic        DIV_END_IN;
    logic [31:0] CORE_HI;
    logic [31:0] CORE_LO;
    logic        CORE_DIV_START;
    logic [31:0] CORE_A, CORE_B, HI_OUT, LO_OUT;
    logic        HILO_WRITE, BUSY, DIV_ZERO_EXC, TIMEOUT_ERR;
    logic [1:0]  dbg_state;

    div_sign_ctrl #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .DIV_REQ        (DIV_REQ),
        .DIV_SIGNED     (DIV_SIGNED),
        .RS             (RS),
        .RT             (RT),
        .DIV_END_IN     (DIV_END_IN),
        .CORE_HI        (CORE_HI),
        .CORE_LO        (CORE_LO),
        .CORE_DIV_START (CORE_DIV_START),
        .CORE_A         (CORE_A),
        .CORE_B         (CORE_B),
        .HI_OUT         (HI_OUT),
        .LO_OUT         (LO_OUT),
        .HILO_WRITE     (HILO_WRITE),
        .BUSY           (BUSY),
        .DIV_ZERO_EXC   (DIV_ZERO_EXC),
        .TIMEOUT_ERR    (TIMEOUT_ERR),
        .dbg_state      (dbg_state)
    );

    // ---------------- core model ----------------
    // Samples start at a rising edge, finishes 32 edges later; done is a
    // level cleared by the next start. core_hang keeps done low forever.
    bit          core_hang = 1'b0;
    logic        core_done = 1'b0;
    int          core_cnt = 0;
    logic [31:0] ca = '0, cb = 32'd1;
    logic [31:0] core_q = '0, core_r = '0;

    always @(posedge clock) begin
        if (reset) begin
            core_done <= 1'b0;
            core_cnt  <= 0;
        end else if (CORE_DIV_START) begin
            core_done <= 1'b0;
            core_cnt  <= 32;
            ca        <= CORE_A;
            cb        <= CORE_B;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !core_hang) begin
                core_done <= 1'b1;
                core_q    <= ca / cb;
                core_r    <= ca % cb;
            end
        end
    end
    assign DIV_END_IN = core_done;
    assign CORE_LO    = core_q;
    assign CORE_HI    = core_r;

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    int cyc = 0;
    int cyc0 = 0;
    int start_cnt = 0, write_cnt = 0, zero_cnt = 0, tmo_cnt = 0;
    logic [63:0] exp_q[$];

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (CORE_DIV_START) start_cnt++;
            if (DIV_ZERO_EXC)   zero_cnt++;
            if (TIMEOUT_ERR)    tmo_cnt++;
            if (HILO_WRITE) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected_write: got HI=0x%0h LO=0x%0h expected no write",
                             HI_OUT, LO_OUT);
                end else begin
                    chk("sb_hilo", {HI_OUT, LO_OUT}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call between edges; returns #1 after the edge that sampled the request.
    task automatic send_req(input logic sgn, input logic [31:0] rs, input logic [31:0] rt);
        DIV_REQ    = 1'b1;
        DIV_SIGNED = sgn;
        RS         = rs;
        RT         = rt;
        @(posedge clock);
        #1;
        cyc0    = cyc;
        DIV_REQ = 1'b0;
    endtask

    // Waits for HILO_WRITE; returns at that negedge. lat=-1 on expiry.
    task automatic wait_write(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (HILO_WRITE) begin
                lat = cyc - cyc0;
                break;
            end
            if (!BUSY) busy_ok = 1'b0;
        end
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] rs, rt, exp_a, exp_b, exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[8];

    task automatic run_op(input vec_t v);
        int lat;
        bit busy_ok;
        int s0, w0;
        s0 = start_cnt;
        w0 = write_cnt;
        exp_q.push_back({v.exp_hi, v.exp_lo});
        send_req(v.sgn, v.rs, v.rt);
        chk("launch_busy",  64'(BUSY), 64'(1));
        chk("launch_start", 64'(CORE_DIV_START), 64'(1));
        chk("core_a", 64'(CORE_A), 64'(v.exp_a));
        chk("core_b", 64'(CORE_B), 64'(v.exp_b));
        wait_write(lat, busy_ok);
        chk("write_latency", 64'(lat), 64'(LAT));
        chk("busy_held", 64'(busy_ok), 64'(1));
        chk("busy_drop_at_write", 64'(BUSY), 64'(0));
        #1;
        chk("one_start", 64'(start_cnt - s0), 64'(1));
        chk("one_write", 64'(write_cnt - w0), 64'(1));
    endtask

    // ---------------- test ----------------
    int          lat;
    bit          busy_ok;
    int          s0, w0, z0, t0;
    logic [63:0] last_hilo;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd100,        32'd7, 32'd2,          32'd14};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'd7,          32'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFD};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd7,          32'd2, 32'd1,          32'hFFFF_FFFD};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd1, 32'd0,          32'h8000_0000};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd1, 32'd0,          32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd100,        32'd7, 32'hFFFF_FFFE,  32'd14};
        vecs[6] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF9,  32'd2, 32'd1,          32'h7FFF_FFFC};
        vecs[7] = '{1'b0, 32'd5,          32'd10,         32'd5,          32'd10, 32'd5,         32'd0};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_core_ab", {CORE_A, CORE_B}, 64'd0);
        chk("rst_hilo",    {HI_OUT, LO_OUT}, 64'd0);
        chk("rst_ctrl", 64'({CORE_DIV_START, HILO_WRITE, BUSY, DIV_ZERO_EXC, TIMEOUT_ERR, dbg_state}), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            run_op(vecs[i]);
            if (i == 0) begin
                @(negedge clock);
                chk("write_one_cycle", 64'(HILO_WRITE), 64'(0));
            end
        end
        last_hilo = {vecs[7].exp_hi, vecs[7].exp_lo};

        // Zero divisor
        @(negedge clock);
        s0 = start_cnt; w0 = write_cnt; z0 = zero_cnt;
        send_req(1'b1, 32'd5, 32'd0);
        chk("zero_pulse", 64'(DIV_ZERO_EXC), 64'(1));
        chk("zero_no_busy", 64'({BUSY, dbg_state}), 64'(0));
        @(posedge clock);
        #1;
        chk("zero_pulse_end", 64'(DIV_ZERO_EXC), 64'(0));
        repeat (40) @(negedge clock);
        #1;
        chk("zero_no_start", 64'(start_cnt - s0), 64'(0));
        chk("zero_no_write", 64'(write_cnt - w0), 64'(0));
        chk("zero_count",    64'(zero_cnt - z0), 64'(1));
        chk("zero_hilo_kept", {HI_OUT, LO_OUT}, last_hilo);

        // Second request at edge 10 is ignored
        @(negedge clock);
        s0 = start_cnt; w0 = write_cnt;
        exp_q.push_back({32'd2, 32'd14});
        send_req(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clock);
        DIV_REQ = 1'b1; RS = 32'd50; RT = 32'd5;
        @(posedge clock);
        #1;
        DIV_REQ = 1'b0;
        wait_write(lat, busy_ok);
        chk("ign_latency", 64'(lat), 64'(LAT));
        repeat (5) @(negedge clock);
        #1;
        chk("ign_one_start", 64'(start_cnt - s0), 64'(1));
        chk("ign_one_write", 64'(write_cnt - w0), 64'(1));

        // Reset asserted at edge 20 of an operation
        @(negedge clock);
        w0 = write_cnt; t0 = tmo_cnt; z0 = zero_cnt;
        send_req(1'b1, 32'hFFFF_FFF9, 32'd2);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_core_ab", {CORE_A, CORE_B}, 64'd0);
        chk("mid_rst_hilo",    {HI_OUT, LO_OUT}, 64'd0);
        chk("mid_rst_ctrl", 64'({CORE_DIV_START, HILO_WRITE, BUSY, DIV_ZERO_EXC, TIMEOUT_ERR, dbg_state}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (45) @(negedge clock);
        #1;
        chk("mid_rst_no_write", 64'(write_cnt - w0), 64'(0));
        chk("mid_rst_no_err", 64'((tmo_cnt - t0) + (zero_cnt - z0)), 64'(0));
        chk("mid_rst_idle", 64'({BUSY, dbg_state}), 64'(0));

        // Timeout: core never raises done
        core_hang = 1'b1;
        @(negedge clock);
        w0 = write_cnt; t0 = tmo_cnt;
        send_req(1'b0, 32'd100, 32'd7);
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (TIMEOUT_ERR) begin
                lat = cyc - cyc0;
                break;
            end
        end
        chk("tmo_latency", 64'(lat), 64'(1 + TIMEOUT));
        chk("tmo_busy_drop", 64'({BUSY, dbg_state}), 64'(0));
        @(negedge clock);
        chk("tmo_pulse_end", 64'(TIMEOUT_ERR), 64'(0));
        #1;
        chk("tmo_count",    64'(tmo_cnt - t0), 64'(1));
        chk("tmo_no_write", 64'(write_cnt - w0), 64'(0));
        core_hang = 1'b0;

        // Normal request after timeout, then back-to-back on the write cycle
        @(negedge clock);
        run_op(vecs[1]);
        run_op(vecs[3]);

        repeat (3) @(negedge clock);
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $finish;
    end

endmodule

// File: doc/div_sign_ctrl.md
Name: div_sign_ctrl

Overview:
Sequencer wrapped around the 32-cycle unsigned restoring divider core.
- Upstream of the core: takes DIV/DIVU requests from the control unit, checks for a zero divisor, converts signed operands to magnitudes and issues the one-cycle core start.
- Downstream of the core: waits for the core's done flag, applies MIPS sign rules to quotient and remainder, and delivers the results to the HI/LO registers with a one-cycle write strobe.
- Holds BUSY so the control unit stalls for the duration of the operation.

Parameters:
WIDTH, 32, operand/result width (core is fixed at 32; other values unsupported)
TIMEOUT, 40, max cycles in WAIT before abandoning the operation

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
DIV_REQ  in  1  request pulse from control unit; sampled only in IDLE
DIV_SIGNED  in  1  1 = DIV (signed), 0 = DIVU; sampled with DIV_REQ
RS  in  32  dividend; sampled with DIV_REQ
RT  in  32  divisor; sampled with DIV_REQ
DIV_END_IN  in  1  core done flag (level, stays high until next start)
CORE_HI  in  32  core remainder
CORE_LO  in  32  core quotient
CORE_DIV_START  out  1  core start, high for exactly one cycle
CORE_A  out  32  magnitude dividend to core (registered)
CORE_B  out  32  magnitude divisor to core (registered)
HI_OUT  out  32  final remainder (registered)
LO_OUT  out  32  final quotient (registered)
HILO_WRITE  out  1  one-cycle strobe: HI_OUT/LO_OUT valid, write HI/LO
BUSY  out  1  high from accepted request until HILO_WRITE or error
DIV_ZERO_EXC  out  1  one-cycle pulse: divisor was zero
TIMEOUT_ERR  out  1  one-cycle pulse: core never finished

Behaviour:
- Interface rule: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset forces state IDLE and clears the wait counter and latched sign flags. All outputs reset to 0.
- Reset mid-operation abandons the operation: no HILO_WRITE, no error pulse.
- States and transitions:
  - IDLE: on DIV_REQ=1 with RT=0: pulse DIV_ZERO_EXC in the next cycle. No core start, no HILO_WRITE, BUSY stays 0, remain IDLE.
  - IDLE: on DIV_REQ=1 with RT≠0:
    - latch neg_q = DIV_SIGNED & (RS[31]^RT[31]) and neg_r = DIV_SIGNED & RS[31];
    - CORE_A <= (DIV_SIGNED & RS[31]) ? -RS : RS (two's complement, 32-bit wrap);
    - CORE_B <= (DIV_SIGNED & RT[31]) ? -RT : RT;
    - BUSY <= 1, go to LAUNCH.
  - LAUNCH: CORE_DIV_START=1 for this cycle only. Clear wait counter, go to WAIT.
  - WAIT: counter increments each cycle.
    - On DIV_ZERO_IN... not used; on DIV_END_IN=1: go to FIX.
    - If the counter reaches TIMEOUT first: pulse TIMEOUT_ERR, BUSY <= 0, go to IDLE.
  - FIX:
    - LO_OUT <= neg_q ? -CORE_LO : CORE_LO;
    - HI_OUT <= neg_r ? -CORE_HI : CORE_HI;
    - HILO_WRITE <= 1 for one cycle, BUSY <= 0, go to IDLE.
- DIV_REQ is ignored whenever state ≠ IDLE; no queuing.
- DIV_END_IN is ignored outside WAIT. A stale high level from a previous operation is cleared by the core at the start edge, so WAIT never sees it.
- Latency with a conforming core: the edge sampling DIV_REQ is edge 0. LAUNCH runs until edge 1, the core finishes after edge 33, WAIT samples done at edge 34, and HILO_WRITE is high in the cycle following edge 35.
- Back-to-back: a new DIV_REQ may be accepted in the same cycle HILO_WRITE is high, since the state is already IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF signed:
  - magnitude 0x80000000 passes unchanged;
  - the core returns quotient 0x80000000, remainder 0;
  - neg_q = 0, so the result is LO=0x80000000, HI=0. This result is required, not undefined.
- HI_OUT/LO_OUT hold their last values except at FIX. The error and zero paths do not modify them.

Test Plan:
- DIVU RS=100, RT=7 -> CORE_DIV_START one cycle; HILO_WRITE one cycle at edge 35; LO_OUT=14, HI_OUT=2; BUSY high edges 0..35.
- DIV RS=-7 (0xFFFFFFF9), RT=2 -> CORE_A=7, CORE_B=2; LO_OUT=0xFFFFFFFD, HI_OUT=0xFFFFFFFF. Also RS=7, RT=-2 -> LO_OUT=0xFFFFFFFD, HI_OUT=1.
- DIV RS=5, RT=0 -> DIV_ZERO_EXC high exactly one cycle after request; CORE_DIV_START, HILO_WRITE, BUSY never assert; HI_OUT/LO_OUT unchanged.
- DIV RS=0x80000000, RT=0xFFFFFFFF -> LO_OUT=0x80000000, HI_OUT=0. Also DIVU 0xFFFFFFFF/1 -> LO=0xFFFFFFFF, HI=0.
- Second DIV_REQ pulsed at edge 10 of an active op -> ignored (single start, single write). Separately, reset asserted at edge 20 -> next cycle all outputs 0, state IDLE, no HILO_WRITE.
- Core model with DIV_END_IN tied 0 -> TIMEOUT_ERR one-cycle pulse after TIMEOUT WAIT cycles, BUSY drops, no HILO_WRITE; next request accepted normally.
